alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Registered front-end/back-end stage for the 4-bit 74181-style ALU. Accepts one operation request per valid/ready handshake and drives the ALU's S/A/B/M/CIN_N inputs from registers. For two-stage arithmetic codes (010 and 011), it runs both ALU passes in sequence. It captures F/COUT_N into a result register and accumulator, then presents the result on a valid/ready response port.

## Interface
- WIDTH, 4: ALU data width. Fixed at 4; other values are unsupported.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_s  in  3  operation select.
- req_m  in  1  1 = logic mode, 0 = arithmetic mode.
- req_a  in  4  operand A.
- req_b  in  4  operand B.
- req_cin_n  in  1  carry-in.
- req_use_acc  in  1  1 = use accumulator in place of req_a.
- alu_s  out  3  registered; drives the ALU's S input.
- alu_a  out  4  registered; drives the ALU's A input.
- alu_b  out  4  registered; drives the ALU's B input.
- alu_m  out  1  registered; drives the ALU's M input.
- alu_cin_n  out  1  registered; drives the ALU's CIN_N input.
- alu_f  in  4  ALU result, combinational from alu_*.
- alu_cout_n  in  1  ALU carry-out, combinational from alu_*.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts.
- rsp_f  out  4  result.
- rsp_cout_n  out  1  carry-out.
- rsp_zero  out  1  rsp_f == 0.
- rsp_err  out  1  illegal request code.
- acc  out  4  accumulator, last legal result.

## Operation
- States: IDLE, STAGE1, STAGE2, RESP.
- IDLE: a request is accepted when req_valid && req_ready. The operand mux selects A = req_use_acc ? acc : req_a.
- Legal codes:
  - M=1: S in 000..100.
  - M=0: S in 000, 001, 010, 011, 100.
  - Codes 110/111 are internal only. Requesting them, or any other code, is illegal.
- Illegal request: goes IDLE→RESP directly with rsp_err=1, rsp_f=0, rsp_cout_n=1. alu_* and acc are unchanged.
- Legal request: loads alu_* from the request and goes IDLE→STAGE1.
- STAGE1 exit when single-stage (any M=1 code, or M=0 with S in 000/001/100):
  - Capture rsp_f=alu_f and acc=alu_f.
  - rsp_cout_n = alu_cout_n when M=0 and S≠000; otherwise 1. The ALU does not define carry for logic ops or pass-through.
  - Go to RESP.
- STAGE1 exit when two-stage (M=0, S=010 or 011):
  - Hold stage-1 F in t_f and stage-1 COUT_N in t_c.
  - Set alu_s = S|3'b100.
  - For 010, alu_a = alu_f; for 011, alu_b = alu_f. alu_cin_n keeps the request value.
  - Go to STAGE2.
- STAGE2: capture rsp_f=alu_f and acc=alu_f, set rsp_cout_n = t_c & alu_cout_n (either pass carrying drives it low), then go to RESP.
- RESP: rsp_valid=1 and rsp_zero = (rsp_f==0). When rsp_ready=1, go to IDLE. rsp_* hold steady while rsp_ready=0.
- Carry value: passed exactly as the ALU produces it, with no inversion.

## Timing
- Reset values, applied while rst_n=0 at a clk edge:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_f=0, rsp_cout_n=1, rsp_zero=0, rsp_err=0, acc=0.
  - alu_s=000, alu_a=0, alu_b=0, alu_m=0, alu_cin_n=1, t_f=0, t_c=1.
- Latency from accept edge to rsp_valid high:
  - Illegal request: 1 cycle.
  - Single-stage: 2 cycles.
  - Two-stage: 3 cycles.
- Throughput: no new request is accepted in RESP. Back-to-back minimum interval is latency+1 cycles.
- ALU outputs are sampled at the end of STAGE1/STAGE2, one full cycle after alu_* were registered.
- Reset mid-operation (any state): abandon the operation, return to IDLE, drop rsp_valid, clear acc. No response is emitted for the aborted request.
- rsp_ready high outside RESP is ignored.
- req_use_acc in the cycle directly after a response uses the acc value updated by that response.

## Structure
- Shared package holds:
  - The state enum.
  - Op-code constants: OP_PASS=000, OP_ADD=001, OP_INCA=010, OP_INCB=011, OP_ADD2=100, STAGE2_BIT=100.
  - A legal-code function is_legal(m,s) and a two-stage function is_two_stage(m,s).
- Single module; no sub-module needed. Operand mux and capture logic are inline.

## Test plan
Bench drives a scripted ALU stub: alu_f = alu_a + alu_b + !alu_cin_n (4-bit), alu_cout_n = carry of that sum, combinational.
- Reset with rst_n=0 for 2 cycles → req_ready=1, rsp_valid=0, acc=0, alu_cin_n=1, rsp_cout_n=1.
- M=0, S=001, A=5, B=3, CIN_N=1 → STAGE1 drives alu_a=5, alu_b=3. rsp_valid 2 cycles after accept with rsp_f=8, rsp_cout_n=0, rsp_zero=0, acc=8.
- M=0, S=010, A=7, B=2, CIN_N=1 → STAGE2 drives alu_s=110, alu_a=9. Result rsp_f=11 at 3 cycles; acc=11.
- M=0, S=110 → rsp_valid after 1 cycle with rsp_err=1, rsp_f=0; acc unchanged.
- req_use_acc=1 with acc=11, M=0, S=001, B=5, CIN_N=1 → rsp_f=0, rsp_zero=1, rsp_cout_n=1. Hold rsp_ready=0 for 4 cycles → outputs stable, req_ready=0 throughout.
- Assert rst_n=0 during STAGE2 → next cycle state IDLE, rsp_valid stays 0, acc=0.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// Shared types, op-code constants and code-classification helpers for the
// 74181-style ALU operation sequencer.
package alu_op_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STAGE1 = 2'd1,
    ST_STAGE2 = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic [2:0] OP_PASS    = 3'b000;
  localparam logic [2:0] OP_ADD     = 3'b001;
  localparam logic [2:0] OP_INCA    = 3'b010;
  localparam logic [2:0] OP_INCB    = 3'b011;
  localparam logic [2:0] OP_ADD2    = 3'b100;
  localparam logic [2:0] STAGE2_BIT = 3'b100;

  // Codes 000..100 are requestable in both modes; 101 and the second-pass
  // codes 110/111 are reserved for internal use.
  function automatic logic is_legal(input logic m, input logic [2:0] s);
    logic unused_m;
    unused_m = m;
    return (s <= OP_ADD2);
  endfunction

  // Arithmetic 010/011 need a second ALU pass fed by the first pass result.
  function automatic logic is_two_stage(input logic m, input logic [2:0] s);
    return !m && ((s == OP_INCA) || (s == OP_INCB));
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Registered request/response wrapper around a 4-bit 74181-style ALU.
// Drives the ALU inputs from flops, sequences two-pass arithmetic codes and
// captures the result into a response register and an accumulator.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_s,
  input  logic             req_m,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_cin_n,
  input  logic             req_use_acc,
  output logic [2:0]       alu_s,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_m,
  output logic             alu_cin_n,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_cout_n,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_f,
  output logic             rsp_cout_n,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] acc
);

  state_e           state_q, state_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_f_q, rsp_f_d;
  logic             rsp_cout_n_q, rsp_cout_n_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [2:0]       alu_s_q, alu_s_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             alu_m_q, alu_m_d;
  logic             alu_cin_n_q, alu_cin_n_d;
  logic [WIDTH-1:0] t_f_q, t_f_d;
  logic             t_c_q, t_c_d;

  // Stage-1 F is retained for debug visibility; the datapath reads it via alu_a/alu_b.
  logic unused_t_f;
  assign unused_t_f = ^t_f_q;

  // Next-state, operand mux and result capture for the sequencer FSM.
  always_comb begin
    state_d      = state_q;
    rsp_f_d      = rsp_f_q;
    rsp_cout_n_d = rsp_cout_n_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    acc_d        = acc_q;
    alu_s_d      = alu_s_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_m_d      = alu_m_q;
    alu_cin_n_d  = alu_cin_n_q;
    t_f_d        = t_f_q;
    t_c_d        = t_c_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          if (is_legal(req_m, req_s)) begin
            alu_s_d     = req_s;
            alu_a_d     = req_use_acc ? acc_q : req_a;
            alu_b_d     = req_b;
            alu_m_d     = req_m;
            alu_cin_n_d = req_cin_n;
            state_d     = ST_STAGE1;
          end else begin
            // Rejected code: answer immediately, ALU and accumulator untouched.
            rsp_f_d      = '0;
            rsp_cout_n_d = 1'b1;
            rsp_zero_d   = 1'b1;
            rsp_err_d    = 1'b1;
            state_d      = ST_RESP;
          end
        end
      end
      ST_STAGE1: begin
        if (is_two_stage(alu_m_q, alu_s_q)) begin
          t_f_d   = alu_f;
          t_c_d   = alu_cout_n;
          alu_s_d = alu_s_q | STAGE2_BIT;
          if (alu_s_q == OP_INCA) alu_a_d = alu_f;
          else                    alu_b_d = alu_f;
          state_d = ST_STAGE2;
        end else begin
          rsp_f_d      = alu_f;
          acc_d        = alu_f;
          // Carry is only meaningful for arithmetic codes other than pass-through.
          rsp_cout_n_d = (!alu_m_q && (alu_s_q != OP_PASS)) ? alu_cout_n : 1'b1;
          rsp_zero_d   = (alu_f == '0);
          rsp_err_d    = 1'b0;
          state_d      = ST_RESP;
        end
      end
      ST_STAGE2: begin
        rsp_f_d      = alu_f;
        acc_d        = alu_f;
        rsp_cout_n_d = t_c_q & alu_cout_n;
        rsp_zero_d   = (alu_f == '0);
        rsp_err_d    = 1'b0;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_f_q      <= '0;
      rsp_cout_n_q <= 1'b1;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      acc_q        <= '0;
      alu_s_q      <= OP_PASS;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_m_q      <= 1'b0;
      alu_cin_n_q  <= 1'b1;
      t_f_q        <= '0;
      t_c_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_f_q      <= rsp_f_d;
      rsp_cout_n_q <= rsp_cout_n_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
      acc_q        <= acc_d;
      alu_s_q      <= alu_s_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_m_q      <= alu_m_d;
      alu_cin_n_q  <= alu_cin_n_d;
      t_f_q        <= t_f_d;
      t_c_q        <= t_c_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_f      = rsp_f_q;
  assign rsp_cout_n = rsp_cout_n_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;
  assign acc        = acc_q;
  assign alu_s      = alu_s_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_m      = alu_m_q;
  assign alu_cin_n  = alu_cin_n_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with an adder-style ALU stub.
module tb_alu_op_sequencer;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_s;
  logic       req_m;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic       req_cin_n;
  logic       req_use_acc;
  logic [2:0] alu_s;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       alu_m;
  logic       alu_cin_n;
  logic [3:0] alu_f;
  logic       alu_cout_n;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_f;
  logic       rsp_cout_n;
  logic       rsp_zero;
  logic       rsp_err;
  logic [3:0] acc;

  int checks = 0;
  int errors = 0;

  // ALU stub: F = A + B + !CIN_N, COUT_N = carry bit of that sum.
  logic [4:0] stub_sum;
  assign stub_sum   = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, !alu_cin_n};
  assign alu_f      = stub_sum[3:0];
  assign alu_cout_n = stub_sum[4];

  alu_op_sequencer #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_s(req_s), .req_m(req_m), .req_a(req_a), .req_b(req_b),
    .req_cin_n(req_cin_n), .req_use_acc(req_use_acc),
    .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_m(alu_m), .alu_cin_n(alu_cin_n),
    .alu_f(alu_f), .alu_cout_n(alu_cout_n),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_f(rsp_f), .rsp_cout_n(rsp_cout_n), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .acc(acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for rsp_valid; returns at a negedge.
  task automatic do_op(input logic m, input logic [2:0] s, input logic [3:0] a,
                       input logic [3:0] b, input logic cin_n, input logic use_acc,
                       output int lat, output logic [3:0] s1_a, output logic [3:0] s1_b,
                       output logic [2:0] s2_s, output logic [3:0] s2_a,
                       output logic [3:0] s2_b);
    @(negedge clk);
    req_m = m; req_s = s; req_a = a; req_b = b;
    req_cin_n = cin_n; req_use_acc = use_acc; req_valid = 1'b1;
    s2_s = 3'b0; s2_a = 4'b0; s2_b = 4'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req_valid = 1'b0;
    s1_a = alu_a;
    s1_b = alu_b;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 2) begin
        s2_s = alu_s; s2_a = alu_a; s2_b = alu_b;
      end
    end
  endtask

  // Accept the pending response and confirm return to IDLE.
  task automatic drain(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_valid_drop"}, 8'(rsp_valid), 8'd0);
    chk({tag, "_ready_back"}, 8'(req_ready), 8'd1);
  endtask

  int         lat;
  logic [3:0] s1_a, s1_b, s2_a, s2_b;
  logic [2:0] s2_s;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_s = 3'b0; req_m = 1'b0;
    req_a = 4'b0; req_b = 4'b0; req_cin_n = 1'b1; req_use_acc = 1'b0; rsp_ready = 1'b0;

    // Reset for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 8'(req_ready), 8'd1);
    chk("rst_rsp_valid", 8'(rsp_valid), 8'd0);
    chk("rst_acc", 8'(acc), 8'd0);
    chk("rst_alu_cin_n", 8'(alu_cin_n), 8'd1);
    chk("rst_rsp_cout_n", 8'(rsp_cout_n), 8'd1);
    rst_n = 1'b1;

    // Single-stage add 5+3.
    do_op(1'b0, 3'b001, 4'd5, 4'd3, 1'b1, 1'b0, lat, s1_a, s1_b, s2_s, s2_a, s2_b);
    chk("add_s1_a", 8'(s1_a), 8'd5);
    chk("add_s1_b", 8'(s1_b), 8'd3);
    chk("add_lat", 8'(lat), 8'd2);
    chk("add_f", 8'(rsp_f), 8'd8);
    chk("add_cout_n", 8'(rsp_cout_n), 8'd0);
    chk("add_zero", 8'(rsp_zero), 8'd0);
    chk("add_err", 8'(rsp_err), 8'd0);
    chk("add_acc", 8'(acc), 8'd8);
    drain("add");

    // Two-stage 010: 7+2=9, then 9+2=11.
    do_op(1'b0, 3'b010, 4'd7, 4'd2, 1'b1, 1'b0, lat, s1_a, s1_b, s2_s, s2_a, s2_b);
    chk("inca_s2_s", 8'(s2_s), 8'd6);
    chk("inca_s2_a", 8'(s2_a), 8'd9);
    chk("inca_s2_b", 8'(s2_b), 8'd2);
    chk("inca_lat", 8'(lat), 8'd3);
    chk("inca_f", 8'(rsp_f), 8'd11);
    chk("inca_cout_n", 8'(rsp_cout_n), 8'd0);
    chk("inca_acc", 8'(acc), 8'd11);
    drain("inca");

    // Illegal internal code 110.
    do_op(1'b0, 3'b110, 4'd3, 4'd3, 1'b1, 1'b0, lat, s1_a, s1_b, s2_s, s2_a, s2_b);
    chk("ill_lat", 8'(lat), 8'd1);
    chk("ill_err", 8'(rsp_err), 8'd1);
    chk("ill_f", 8'(rsp_f), 8'd0);
    chk("ill_cout_n", 8'(rsp_cout_n), 8'd1);
    chk("ill_acc", 8'(acc), 8'd11);
    chk("ill_alu_a_kept", 8'(alu_a), 8'd9);
    chk("ill_alu_s_kept", 8'(alu_s), 8'd6);
    drain("ill");

    // Accumulator operand: 11+5 wraps to 0 with carry; hold response 4 cycles.
    do_op(1'b0, 3'b001, 4'd0, 4'd5, 1'b1, 1'b1, lat, s1_a, s1_b, s2_s, s2_a, s2_b);
    chk("uacc_s1_a", 8'(s1_a), 8'd11);
    chk("uacc_lat", 8'(lat), 8'd2);
    chk("uacc_err", 8'(rsp_err), 8'd0);
    for (int i = 0; i < 4; i++) begin
      chk("hold_valid", 8'(rsp_valid), 8'd1);
      chk("hold_f", 8'(rsp_f), 8'd0);
      chk("hold_zero", 8'(rsp_zero), 8'd1);
      chk("hold_cout_n", 8'(rsp_cout_n), 8'd1);
      chk("hold_req_ready", 8'(req_ready), 8'd0);
      @(negedge clk);
    end
    drain("uacc");

    // Two-stage 011 with carry-in: 4+6+1=11, then 4+11+1=16 -> F=0, carry.
    do_op(1'b0, 3'b011, 4'd4, 4'd6, 1'b0, 1'b0, lat, s1_a, s1_b, s2_s, s2_a, s2_b);
    chk("incb_s2_s", 8'(s2_s), 8'd7);
    chk("incb_s2_a", 8'(s2_a), 8'd4);
    chk("incb_s2_b", 8'(s2_b), 8'd11);
    chk("incb_lat", 8'(lat), 8'd3);
    chk("incb_f", 8'(rsp_f), 8'd0);
    chk("incb_cout_n", 8'(rsp_cout_n), 8'd0);
    chk("incb_zero", 8'(rsp_zero), 8'd1);
    drain("incb");

    // Logic mode: carry forced high even though the stub reports none.
    do_op(1'b1, 3'b001, 4'd2, 4'd3, 1'b1, 1'b0, lat, s1_a, s1_b, s2_s, s2_a, s2_b);
    chk("logic_lat", 8'(lat), 8'd2);
    chk("logic_f", 8'(rsp_f), 8'd5);
    chk("logic_cout_n", 8'(rsp_cout_n), 8'd1);
    chk("logic_acc", 8'(acc), 8'd5);
    drain("logic");

    // Illegal 101 in logic mode.
    do_op(1'b1, 3'b101, 4'd1, 4'd1, 1'b1, 1'b0, lat, s1_a, s1_b, s2_s, s2_a, s2_b);
    chk("ill101_lat", 8'(lat), 8'd1);
    chk("ill101_err", 8'(rsp_err), 8'd1);
    chk("ill101_acc", 8'(acc), 8'd5);
    drain("ill101");

    // Reset asserted while in STAGE2.
    @(negedge clk);
    req_m = 1'b0; req_s = 3'b010; req_a = 4'd7; req_b = 4'd2;
    req_cin_n = 1'b1; req_use_acc = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_in_stage2", 8'(alu_s), 8'd6);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_valid", 8'(rsp_valid), 8'd0);
    chk("abort_acc", 8'(acc), 8'd0);
    chk("abort_ready", 8'(req_ready), 8'd1);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_rsp", 8'(rsp_valid), 8'd0);
    end

    // Cleared accumulator feeds the next request: 0+3.
    do_op(1'b0, 3'b001, 4'd9, 4'd3, 1'b1, 1'b1, lat, s1_a, s1_b, s2_s, s2_a, s2_b);
    chk("post_rst_f", 8'(rsp_f), 8'd3);
    chk("post_rst_acc", 8'(acc), 8'd3);
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
